forward_hazard_unit: RTL and testbench

- Tracks the destination registers of in-flight instructions through the EX, MEM and WB stages of the 5-stage RISC-V pipeline.
- Generates the 2-bit select codes for the two 32-bit 3x1 operand multiplexers in front of the ALU:
  - 00 = register file
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB writeback value
- Detects load-use hazards, requests a decode stall, and injects a bubble into EX.
- Counts stall cycles for performance monitoring.

---
 rtl/forward_hazard_unit.sv | 122 ++++++++++++
 tb/tb_forward_hazard_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Operand forwarding select and load-use stall detection for a 5-stage RISC-V pipeline.
// Tracks destination registers through EX, MEM and WB, and counts stall cycles.
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  load_use_stall,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic                  ex_valid, ex_uses_rs1, ex_uses_rs2, ex_reg_write, ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic                  mem_valid, mem_reg_write, mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic mem_can_fwd, wb_can_fwd, ex_is_load;

    // A load in MEM has no data yet, so it is never a forwarding source.
    always_comb begin
        mem_can_fwd = mem_valid && mem_reg_write && !mem_mem_read && (mem_rd != '0);
        wb_can_fwd  = wb_valid && wb_reg_write && (wb_rd != '0);
        ex_is_load  = ex_valid && ex_mem_read && ex_reg_write && (ex_rd != '0);
    end

    always_comb begin
        load_use_stall = 1'b0;
        if (!flush && id_valid && ex_is_load &&
            ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd))))
            load_use_stall = 1'b1;
    end

    always_comb begin
        fwd_a_sel = SEL_RF;
        if (ex_valid && ex_uses_rs1) begin
            if (mem_can_fwd && (mem_rd == ex_rs1))
                fwd_a_sel = SEL_MEM;
            else if (wb_can_fwd && (wb_rd == ex_rs1))
                fwd_a_sel = SEL_WB;
        end
    end

    always_comb begin
        fwd_b_sel = SEL_RF;
        if (ex_valid && ex_uses_rs2) begin
            if (mem_can_fwd && (mem_rd == ex_rs2))
                fwd_b_sel = SEL_MEM;
            else if (wb_can_fwd && (wb_rd == ex_rs2))
                fwd_b_sel = SEL_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_uses_rs1   <= 1'b0;
            ex_uses_rs2   <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            stall_count   <= '0;
        end else if (advance) begin
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            if (flush || load_use_stall) begin
                ex_valid     <= 1'b0;
                ex_rs1       <= '0;
                ex_rs2       <= '0;
                ex_uses_rs1  <= 1'b0;
                ex_uses_rs2  <= 1'b0;
                ex_rd        <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_rs1       <= id_rs1;
                ex_rs2       <= id_rs2;
                ex_uses_rs1  <= id_uses_rs1;
                ex_uses_rs2  <= id_uses_rs2;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
            if (load_use_stall && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit; a second instance with a 3-bit counter
// exercises stall counter saturation within a short run.
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       advance = 1'b1;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        load_use_stall;
    logic [15:0] stall_count;
    logic [1:0]  sat_a_sel, sat_b_sel;
    logic        sat_stall;
    logic [2:0]  sat_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(sat_a_sel), .fwd_b_sel(sat_b_sel),
        .load_use_stall(sat_stall), .stall_count(sat_count)
    );

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic drive_nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        advance = 1'b1;
        flush = 1'b0;
        drive_nop();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        advance = 1'($urandom_range(0, 1));
        flush = 1'($urandom_range(0, 1));
        drive(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1,
              5'($urandom_range(1, 31)), 1'b1, 1'b1);
        repeat (2) tick();
        tests_run++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || load_use_stall !== 1'b0 || stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_assert: a=%b b=%b stall=%b cnt=%0d, required 00 00 0 0",
                     fwd_a_sel, fwd_b_sel, load_use_stall, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        tests_run++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || load_use_stall !== 1'b0 || stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_release: a=%b b=%b stall=%b cnt=%0d, required 00 00 0 0",
                     fwd_a_sel, fwd_b_sel, load_use_stall, stall_count);
        end
    endtask

    task automatic test_exmem_fwd();
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01 || load_use_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL exmem_fwd: a=%b b=%b stall=%b, required 01 01 0",
                     fwd_a_sel, fwd_b_sel, load_use_stall);
        end
    endtask

    task automatic test_priority();
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL priority_mem_over_wb: a=%b b=%b, required 01 00", fwd_a_sel, fwd_b_sel);
        end
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive_nop();
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL wb_fwd: a=%b b=%b, required 10 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b1 || stall_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL load_use_detect: stall=%b cnt=%0d, required 1 0", load_use_stall, stall_count);
        end
        tick();
        tests_run++;
        if (load_use_stall !== 1'b0 || stall_count !== 16'd1 || fwd_a_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_use_bubble: stall=%b cnt=%0d a=%b, required 0 1 00",
                     load_use_stall, stall_count, fwd_a_sel);
        end
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00 || stall_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL load_use_wb_fwd: a=%b b=%b cnt=%0d, required 10 00 1",
                     fwd_a_sel, fwd_b_sel, stall_count);
        end
    endtask

    task automatic test_x0_unused();
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_load_no_stall: stall=%b, required 0", load_use_stall);
        end
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL x0_no_fwd: a=%b b=%b, required 00 00", fwd_a_sel, fwd_b_sel);
        end
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b0 || stall_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL unused_rs_no_stall: stall=%b cnt=%0d, required 0 1", load_use_stall, stall_count);
        end
    endtask

    task automatic test_hold();
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        advance = 1'b0;
        drive(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
        repeat (2) tick();
        tests_run++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01 || stall_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL hold_selects: a=%b b=%b cnt=%0d, required 01 01 1", fwd_a_sel, fwd_b_sel, stall_count);
        end
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        advance = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (load_use_stall !== 1'b1 || stall_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL hold_stall_count: stall=%b cnt=%0d, required 1 1", load_use_stall, stall_count);
        end
        advance = 1'b1;
        tick();
        tests_run++;
        if (stall_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL stall_count_inc: cnt=%0d, required 2", stall_count);
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_kills_stall: stall=%b, required 0", load_use_stall);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        tick();
        drive_nop();
        tests_run++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL flush_bubble: a=%b b=%b cnt=%0d, required 00 00 2", fwd_a_sel, fwd_b_sel, stall_count);
        end
    endtask

    task automatic test_back_to_back_saturation();
        drain();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
            tick();
            if (i == 4) begin
                tests_run++;
                if (sat_count !== 3'd7) begin
                    tests_failed++;
                    $display("FAIL sat_reach_max: cnt=%0d, required 7", sat_count);
                end
            end
        end
        drive_nop();
        tests_run++;
        if (sat_count !== 3'd7) begin
            tests_failed++;
            $display("FAIL sat_hold_max: cnt=%0d, required 7", sat_count);
        end
        tests_run++;
        if (stall_count !== 16'd12) begin
            tests_failed++;
            $display("FAIL back_to_back_count: cnt=%0d, required 12", stall_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (load_use_stall !== 1'b0 || stall_count !== 16'd0 || sat_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: stall=%b cnt=%0d sat=%0d, required 0 0 0",
                     load_use_stall, stall_count, sat_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_exmem_fwd();
        test_priority();
        test_load_use();
        test_x0_unused();
        test_hold();
        test_flush();
        test_back_to_back_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
